// File: rtl/music_mem_pkg.sv
// Shared definitions for the song-memory write path: FSM states, table layout and table addressing.
// Define MUSIC_WR_CHECKSUM_EN to add a per-song checksum word to the index table.
package music_mem_pkg;

    localparam int IDX_W = 5;

`ifdef MUSIC_WR_CHECKSUM_EN
    localparam int TABLE_WORDS = 3;
    localparam int DATA_BASE   = 96;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STREAM   = 3'd1,
        WR_START = 3'd2,
        WR_END   = 3'd3,
        WR_SUM   = 3'd4,
        DONE     = 3'd5
    } wr_state_e;
`else
    localparam int TABLE_WORDS = 2;
    localparam int DATA_BASE   = 64;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STREAM   = 3'd1,
        WR_START = 3'd2,
        WR_END   = 3'd3,
        DONE     = 3'd4
    } wr_state_e;
`endif

    typedef enum logic [1:0] {
        FLD_START = 2'd0,
        FLD_END   = 2'd1,
        FLD_SUM   = 2'd2
    } tbl_field_e;

    // Zero-extended slot address; callers narrow it to their RAM address width.
    function automatic int unsigned tbl_addr(input logic [IDX_W-1:0] idx, input tbl_field_e field);
        return 32'(idx) * 32'(TABLE_WORDS) + 32'(field);
    endfunction

endpackage

// File: rtl/music_memory_writer_if.sv
// Loader-side stream, control and RAM write port of the song-memory writer.
interface music_memory_writer_if
    import music_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              start;
    logic [IDX_W-1:0]  song_index;
    logic              clear_all;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              busy;
    logic              done;
    logic              overflow;

    modport slave (
        input  start, song_index, clear_all, s_data, s_valid, s_last,
        output s_ready, mem_addr, mem_wdata, mem_we, busy, done, overflow
    );

    modport master (
        output start, song_index, clear_all, s_data, s_valid, s_last,
        input  s_ready, mem_addr, mem_wdata, mem_we, busy, done, overflow
    );
endinterface

// File: rtl/music_wr_ptr.sv
// Song RAM write pointer: reloads BASE on clear, counts up, and saturates one past MEM_LAST
// with a sticky carry so the pointer never wraps back into the index table.
module music_wr_ptr #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] BASE     = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0] MEM_LAST = {ADDR_W{1'b1}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              incr,
    output logic [ADDR_W-1:0] value,
    output logic              at_last,
    output logic              carry
);
    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] ptr_r;
    logic              carry_r;

    // Pointer register with saturation once the last address has been consumed.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            ptr_r   <= BASE;
            carry_r <= 1'b0;
        end else if (incr && !carry_r) begin
            ptr_r   <= ptr_r + ONE;
            carry_r <= (ptr_r == MEM_LAST);
        end else begin
            ptr_r   <= ptr_r;
            carry_r <= carry_r;
        end
    end

    assign value   = ptr_r;
    assign at_last = (ptr_r == MEM_LAST) && !carry_r;
    assign carry   = carry_r;
endmodule

// File: rtl/music_memory_writer.sv
// Writes one song's sample stream into the song RAM, then its index-table entry (start, end[, sum]).
// Define MUSIC_WR_CHECKSUM_EN for the three-word table entry with a wrapping sample checksum.
module music_memory_writer
    import music_mem_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] MEM_LAST = {ADDR_W{1'b1}}
) (
    input  logic                 clock,
    input  logic                 reset,
    music_memory_writer_if.slave bus
);
    wr_state_e         state_r, next_state_s;
    logic [IDX_W-1:0]  idx_r;
    logic [ADDR_W-1:0] start_addr_r, end_addr_r;
    logic [ADDR_W-1:0] ptr_s;
    logic              ptr_at_last_s, ptr_carry_s, ptr_clear_s;
    logic              hs_s, term_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              mem_we_r, s_ready_r, busy_r, done_r, overflow_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
`ifdef MUSIC_WR_CHECKSUM_EN
    logic [DATA_W-1:0] sum_r;
`endif

    music_wr_ptr #(
        .ADDR_W   (ADDR_W),
        .BASE     (ADDR_W'(DATA_BASE)),
        .MEM_LAST (MEM_LAST)
    ) u_wr_ptr (
        .clock   (clock),
        .reset   (reset),
        .clear   (ptr_clear_s),
        .incr    (hs_s),
        .value   (ptr_s),
        .at_last (ptr_at_last_s),
        .carry   (ptr_carry_s)
    );

    // Next state and the RAM write requested for this cycle.
    always_comb begin
        next_state_s = state_r;
        ptr_clear_s  = 1'b0;
        hs_s         = 1'b0;
        term_s       = 1'b0;
        wr_en_s      = 1'b0;
        wr_addr_s    = {ADDR_W{1'b0}};
        wr_data_s    = {DATA_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (bus.start) next_state_s = STREAM;
                else           ptr_clear_s  = bus.clear_all;
            end
            STREAM: begin
                hs_s      = bus.s_valid & s_ready_r;
                // A saturated pointer still accepts one sample so the song closes as an empty entry.
                term_s    = hs_s & (bus.s_last | ptr_at_last_s | ptr_carry_s);
                wr_en_s   = hs_s & ~ptr_carry_s;
                wr_addr_s = ptr_s;
                wr_data_s = bus.s_data;
                if (term_s) next_state_s = WR_START;
                else        next_state_s = STREAM;
            end
            WR_START: begin
                wr_en_s      = 1'b1;
                wr_addr_s    = ADDR_W'(tbl_addr(idx_r, FLD_START));
                wr_data_s    = DATA_W'(start_addr_r);
                next_state_s = WR_END;
            end
            WR_END: begin
                wr_en_s      = 1'b1;
                wr_addr_s    = ADDR_W'(tbl_addr(idx_r, FLD_END));
                wr_data_s    = DATA_W'(end_addr_r);
`ifdef MUSIC_WR_CHECKSUM_EN
                next_state_s = WR_SUM;
            end
            WR_SUM: begin
                wr_en_s      = 1'b1;
                wr_addr_s    = ADDR_W'(tbl_addr(idx_r, FLD_SUM));
                wr_data_s    = sum_r;
                next_state_s = DONE;
`else
                next_state_s = DONE;
`endif
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, registered RAM port and status outputs, per-song bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= IDLE;
            idx_r        <= {IDX_W{1'b0}};
            start_addr_r <= {ADDR_W{1'b0}};
            end_addr_r   <= {ADDR_W{1'b0}};
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            s_ready_r    <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            overflow_r   <= 1'b0;
`ifdef MUSIC_WR_CHECKSUM_EN
            sum_r        <= {DATA_W{1'b0}};
`endif
        end else begin
            state_r   <= next_state_s;
            mem_we_r  <= wr_en_s;
            s_ready_r <= (next_state_s == STREAM);
            busy_r    <= (next_state_s != IDLE);
            done_r    <= (state_r == DONE);
            if (wr_en_s) begin
                mem_addr_r  <= wr_addr_s;
                mem_wdata_r <= wr_data_s;
            end
            if (state_r == IDLE && bus.start) begin
                idx_r        <= bus.song_index;
                start_addr_r <= ptr_s;
                overflow_r   <= 1'b0;
`ifdef MUSIC_WR_CHECKSUM_EN
                sum_r        <= {DATA_W{1'b0}};
`endif
            end
            if (hs_s) begin
                end_addr_r <= ptr_carry_s ? MEM_LAST : ptr_s;
                if (ptr_carry_s || (ptr_at_last_s && !bus.s_last)) overflow_r <= 1'b1;
`ifdef MUSIC_WR_CHECKSUM_EN
                sum_r <= sum_r + bus.s_data;
`endif
            end
        end
    end

    assign bus.s_ready   = s_ready_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_music_memory_writer.sv
// Scoreboard bench for music_memory_writer (default build, MEM_LAST reduced to 70 to reach overflow).
module tb_music_memory_writer;
    localparam logic [15:0] LAST = 16'd70;
    localparam logic [15:0] BASE = 16'd64;

    typedef struct {
        bit          is_done;
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    music_memory_writer_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    music_memory_writer #(.ADDR_W(16), .DATA_W(16), .MEM_LAST(LAST)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [15:0] m_ptr = BASE;
    logic [15:0] m_start = 16'd0;
    logic [15:0] m_end = 16'd0;
    logic [4:0]  m_idx = 5'd0;
    logic        m_carry = 1'b0;
    logic        m_ovf = 1'b0;
    int          nacc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Every RAM write and done pulse must match the next scoreboard entry, including its cycle.
    always @(negedge clock) begin
        if (bus.mem_we) begin
            if (sb.size() == 0 || sb[0].is_done) begin
                check_eq("unexpected_write", 32'(bus.mem_we), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
                check_eq("wr_data", 32'(bus.mem_wdata), 32'(mon_e.data));
                check_eq("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
        if (bus.done) begin
            if (sb.size() == 0 || !sb[0].is_done) begin
                check_eq("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic model_hs(input logic [15:0] d, input logic last);
        int p;
        bit term;
        p    = cyc + 1;
        term = last;
        if (m_carry) begin
            m_end = LAST;
            m_ovf = 1'b1;
            term  = 1'b1;
        end else begin
            sb.push_back('{1'b0, m_ptr, d, p});
            m_end = m_ptr;
            if (m_ptr == LAST) begin
                m_carry = 1'b1;
                m_ptr   = LAST + 16'd1;
                term    = 1'b1;
                if (!last) m_ovf = 1'b1;
            end else begin
                m_ptr = m_ptr + 16'd1;
            end
        end
        if (term) begin
            sb.push_back('{1'b0, {10'd0, m_idx, 1'b0}, m_start, p + 1});
            sb.push_back('{1'b0, {10'd0, m_idx, 1'b1}, m_end, p + 2});
            sb.push_back('{1'b1, 16'd0, 16'd0, p + 3});
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.clear_all  = 1'b0;
        bus.song_index = 5'd0;
        bus.s_valid    = 1'b0;
        bus.s_last     = 1'b0;
        bus.s_data     = 16'd0;
        tick(2);
        reset   = 1'b0;
        m_ptr   = BASE;
        m_carry = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic begin_song(input logic [4:0] idx, input logic clr, input bit taken);
        bus.start      = 1'b1;
        bus.song_index = idx;
        bus.clear_all  = clr;
        if (taken) begin
            m_idx   = idx;
            m_start = m_ptr;
            m_ovf   = 1'b0;
        end
        tick(1);
        bus.start     = 1'b0;
        bus.clear_all = 1'b0;
    endtask

    task automatic clear_ptr();
        bus.clear_all = 1'b1;
        tick(1);
        bus.clear_all = 1'b0;
        m_ptr   = BASE;
        m_carry = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic last, input int wait_max, output bit acc);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        acc = 1'b0;
        for (int t = 0; t < wait_max && !acc; t++) begin
            if (bus.s_ready) begin
                model_hs(d, last);
                acc = 1'b1;
            end
            tick(1);
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_song(input logic [15:0] d0, input int n, input bit with_last, input bit gap,
                             input int wait_max, output int cnt);
        bit acc;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            send(d0 + 16'(i), with_last && (i == n - 1), wait_max, acc);
            if (acc) cnt++;
            if (gap) tick(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        do_reset();
        check_eq("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_overflow", 32'(bus.overflow), 32'd0);

        // Song idx 3, four back-to-back samples at 64..67.
        begin_song(5'd3, 1'b0, 1'b1);
        check_eq("t1_busy", 32'(bus.busy), 32'd1);
        send_song(16'hA001, 4, 1'b1, 1'b0, 8, nacc);
        tick(6);
        check_eq("t1_accepted", 32'(nacc), 32'd4);
        check_eq("t1_idle_busy", 32'(bus.busy), 32'd0);
        check_eq("t1_idle_ready", 32'(bus.s_ready), 32'd0);

        // One-sample song idx 0 at 68: start == end.
        begin_song(5'd0, 1'b0, 1'b1);
        send_song(16'hB001, 1, 1'b1, 1'b0, 8, nacc);
        tick(6);
        check_eq("t2_accepted", 32'(nacc), 32'd1);

        // s_valid toggling every other cycle.
        do_reset();
        begin_song(5'd5, 1'b0, 1'b1);
        send_song(16'hC001, 4, 1'b1, 1'b1, 8, nacc);
        tick(6);
        check_eq("t3_accepted", 32'(nacc), 32'd4);

        // Five samples from 68 with MEM_LAST=70: three stored, forced end, overflow.
        begin_song(5'd7, 1'b0, 1'b1);
        send_song(16'hD001, 5, 1'b1, 1'b0, 4, nacc);
        tick(4);
        check_eq("t4_accepted", 32'(nacc), 32'd3);
        check_eq("t4_overflow", 32'(bus.overflow), 32'(m_ovf));
        // Saturated pointer: next song closes on its first sample as an empty entry.
        begin_song(5'd8, 1'b0, 1'b1);
        check_eq("t4_ovf_cleared", 32'(bus.overflow), 32'd0);
        send_song(16'hD101, 2, 1'b1, 1'b0, 4, nacc);
        tick(4);
        check_eq("t4_sat_accepted", 32'(nacc), 32'd1);
        check_eq("t4_sat_overflow", 32'(bus.overflow), 32'(m_ovf));

        // Reset mid-stream: no table write, pointer back at 64.
        do_reset();
        begin_song(5'd9, 1'b0, 1'b1);
        send_song(16'hE001, 2, 1'b0, 1'b0, 8, nacc);
        do_reset();
        check_eq("t5_busy", 32'(bus.busy), 32'd0);
        begin_song(5'd1, 1'b0, 1'b1);
        send_song(16'hE101, 1, 1'b1, 1'b0, 8, nacc);
        tick(6);

        // start wins over clear_all; start/clear_all while busy are ignored.
        begin_song(5'd2, 1'b1, 1'b1);
        begin_song(5'd30, 1'b1, 1'b0);
        send_song(16'hF001, 1, 1'b1, 1'b0, 8, nacc);
        tick(6);
        check_eq("t6_accepted", 32'(nacc), 32'd1);
        clear_ptr();
        begin_song(5'd4, 1'b0, 1'b1);
        send_song(16'hF101, 1, 1'b1, 1'b0, 8, nacc);
        tick(6);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
